ce_acc: RTL and testbench



---
 rtl/ce_acc_if.sv | 29 ++
 rtl/ce_acc.sv | 163 ++++++++++++++++
 tb/tb_ce_acc.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ce_acc_if.sv
// Beat/result bus of the channel-folded convolution element.
// The master side is the window generator plus the output buffer; the slave side is ce_acc.
interface ce_acc_if #(
  parameter int LANES  = 4,
  parameter int KERNEL = 3,
  parameter int N      = 2,
  parameter int M      = 2,
  parameter int OUT_W  = N + M + 15
);
  logic [LANES*KERNEL*KERNEL*N-1:0] data2conv;
  logic [LANES*KERNEL*KERNEL*M-1:0] w;
  logic [OUT_W-1:0]                 bias;
  logic                             en_in;
  logic                             in_ready;
  logic [OUT_W-1:0]                 d_out;
  logic                             en_out;
  logic                             out_ready;
  logic                             sat_flag;

  modport master (
    output data2conv, w, bias, en_in, out_ready,
    input  in_ready, d_out, en_out, sat_flag
  );

  modport slave (
    input  data2conv, w, bias, en_in, out_ready,
    output in_ready, d_out, en_out, sat_flag
  );
endinterface

// File: rtl/ce_acc.sv
// Channel-folded convolution element: folds BEATS beats of LANES channels into one
// biased, rounded, optionally rectified and saturated result behind a 4-stage pipeline.
module ce_acc #(
  parameter int LANES  = 4,
  parameter int KERNEL = 3,
  parameter int N      = 2,
  parameter int M      = 2,
  parameter int BEATS  = 4,
  parameter int SR     = 2,
  parameter int RELU   = 1,
  parameter int OUT_W  = N + M + 15
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  ce_acc_if.slave bus
);
  localparam int KK     = KERNEL * KERNEL;
  localparam int PW     = N + M;
  localparam int GROW_W = N + M + $clog2(KK * LANES * BEATS) + 1;
  // The bias is pre-shifted by SR before it enters the accumulator, so leave room for it.
  localparam int BIAS_W = OUT_W + SR;
  localparam int ACC_W  = ((BIAS_W > GROW_W) ? BIAS_W : GROW_W) + 1;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RND_I  = (SR > 0) ? (1 << (SR - 1)) : 0;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(RND_I);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    s1_v_q, s1_first_q, s1_last_q;
  logic [OUT_W-1:0]        s1_bias_q;
  logic signed [ACC_W-1:0] s1_lane_q [LANES];
  logic                    s2_v_q, s2_first_q, s2_last_q;
  logic [OUT_W-1:0]        s2_bias_q;
  logic signed [ACC_W-1:0] s2_sum_q;
  logic                    s3_v_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    en_out_q;
  logic                    sat_q, sat_d;

  logic                    stall_s, beat_s, first_s, last_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] lane_sum_s [LANES];
  logic signed [ACC_W-1:0] sum_s, bias_sh_s, rnd_sum_s, shr_s, res_s;

  assign stall_s      = en_out_q & ~bus.out_ready;
  assign beat_s       = bus.en_in & ~stall_s;
  assign first_s      = (cnt_q == '0);
  assign last_s       = (cnt_q == CNT_LAST);
  assign bus.in_ready = ~stall_s;
  assign bus.d_out    = dout_q;
  assign bus.en_out   = en_out_q;
  assign bus.sat_flag = sat_q;

  // Per-lane dot product of the incoming window against its weights.
  always_comb begin
    prod_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_s[l] = '0;
      for (int p = 0; p < KK; p++) begin
        prod_s = $signed(bus.data2conv[(l*KK+p)*N +: N]) * $signed(bus.w[(l*KK+p)*M +: M]);
        lane_sum_s[l] = lane_sum_s[l] + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
      end
    end
  end

  // Next-state for beat counter, accumulator and the rounded/clamped result.
  always_comb begin
    cnt_d = cnt_q;
    if (beat_s) begin
      cnt_d = last_s ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_s = sum_s + s1_lane_q[l];
    end

    bias_sh_s = {{(ACC_W-OUT_W){s2_bias_q[OUT_W-1]}}, s2_bias_q} <<< SR;
    if (s2_first_q) begin
      acc_d = bias_sh_s + s2_sum_q;
    end else begin
      acc_d = acc_q + s2_sum_q;
    end

    rnd_sum_s = acc_q + RND;
    shr_s     = rnd_sum_s >>> SR;
    res_s     = shr_s;
    sat_d     = 1'b0;
    if ((RELU != 0) && shr_s[ACC_W-1]) begin
      res_s = '0;
    end else if (shr_s > OUT_MAX) begin
      res_s = OUT_MAX;
      sat_d = 1'b1;
    end else if (shr_s < OUT_MIN) begin
      res_s = OUT_MIN;
      sat_d = 1'b1;
    end else begin
      res_s = shr_s;
    end
    dout_d = res_s[OUT_W-1:0];
  end

  // Pipeline registers; a stall freezes everything, clear drops the partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      for (int l = 0; l < LANES; l++) s1_lane_q[l] <= '0;
      s2_v_q     <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bias_q  <= '0;
      s2_sum_q   <= '0;
      s3_v_q     <= 1'b0;
      acc_q      <= '0;
      dout_q     <= '0;
      en_out_q   <= 1'b0;
      sat_q      <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      en_out_q <= 1'b0;
    end else if (!stall_s) begin
      cnt_q  <= cnt_d;
      s1_v_q <= beat_s;
      if (beat_s) begin
        s1_first_q <= first_s;
        s1_last_q  <= last_s;
        s1_bias_q  <= bus.bias;
        for (int l = 0; l < LANES; l++) s1_lane_q[l] <= lane_sum_s[l];
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_bias_q  <= s1_bias_q;
        s2_sum_q   <= sum_s;
      end
      s3_v_q <= s2_v_q & s2_last_q;
      if (s2_v_q) begin
        acc_q <= acc_d;
      end
      // Without a stall any pending result is being consumed this cycle.
      en_out_q <= s3_v_q;
      if (s3_v_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end
endmodule

// File: tb/tb_ce_acc.sv
// Directed scoreboard bench for ce_acc: three instances (default, RELU=0, OUT_W=6/RELU=0)
// see identical stimulus; expected results are queued per instance when a group completes.
module tb_ce_acc;
  localparam int DW = 72;

  typedef struct packed {
    logic signed [31:0] v;
    logic               s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, clear, en_in, out_ready;
  logic [DW-1:0] data_v, w_v;
  logic [18:0]   bias_v;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_res [3];
  exp_t sbq [3][$];
  int   beat_n, grp_sum, grp_bias, tw, base;
  logic ok;
  int   relu_of [3] = '{1, 0, 0};
  int   ow_of   [3] = '{19, 19, 6};

  always #5 clk = ~clk;

  ce_acc_if #(.OUT_W(19)) if0 ();
  ce_acc_if #(.OUT_W(19)) if1 ();
  ce_acc_if #(.OUT_W(6))  if2 ();

  assign if0.data2conv = data_v;  assign if1.data2conv = data_v;  assign if2.data2conv = data_v;
  assign if0.w = w_v;             assign if1.w = w_v;             assign if2.w = w_v;
  assign if0.bias = bias_v;       assign if1.bias = bias_v;       assign if2.bias = bias_v[5:0];
  assign if0.en_in = en_in;       assign if1.en_in = en_in;       assign if2.en_in = en_in;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  ce_acc #(.RELU(1)) u_main (.clk(clk), .rst(rst), .clear(clear), .bus(if0));
  ce_acc #(.RELU(0)) u_nr   (.clk(clk), .rst(rst), .clear(clear), .bus(if1));
  ce_acc #(.RELU(0), .OUT_W(6)) u_s6 (.clk(clk), .rst(rst), .clear(clear), .bus(if2));

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] fillv(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 2; i++) r[i*2 +: 2] = 2'(v);
    return r;
  endfunction

  function automatic int dot(input logic [DW-1:0] d, input logic [DW-1:0] w);
    int s = 0;
    for (int i = 0; i < DW / 2; i++) s += int'($signed(d[i*2 +: 2])) * int'($signed(w[i*2 +: 2]));
    return s;
  endfunction

  function automatic exp_t model(input int sum, input int b, input int relu, input int ow);
    exp_t e;
    int acc, r, hi, lo;
    acc = b * 4 + sum;
    r   = (acc + 2) >>> 2;
    if (relu != 0 && r < 0) r = 0;
    hi  = (1 << (ow - 1)) - 1;
    lo  = -(1 << (ow - 1));
    e.s = 1'b0;
    if (r > hi) begin r = hi; e.s = 1'b1; end
    else if (r < lo) begin r = lo; e.s = 1'b1; end
    e.v = r;
    return e;
  endfunction

  task automatic pop_chk(input int idx, input int obs, input logic sat);
    exp_t e;
    n_res[idx]++;
    if (sbq[idx].size() == 0) begin
      chk($sformatf("unexpected_out%0d_queue_depth", idx), sbq[idx].size(), 1);
    end else begin
      e = sbq[idx].pop_front();
      chk($sformatf("d_out%0d", idx), obs, int'(e.v));
      chk($sformatf("sat_flag%0d", idx), int'(sat), int'(e.s));
    end
  endtask

  // Output monitors: compare on every consumed result.
  always @(negedge clk) begin
    if (!rst && if0.en_out && if0.out_ready) pop_chk(0, int'($signed(if0.d_out)), if0.sat_flag);
    if (!rst && if1.en_out && if1.out_ready) pop_chk(1, int'($signed(if1.d_out)), if1.sat_flag);
    if (!rst && if2.en_out && if2.out_ready) pop_chk(2, int'($signed(if2.d_out)), if2.sat_flag);
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] w, input int bv);
    data_v = d;
    w_v    = w;
    bias_v = 19'(bv);
    en_in  = 1'b1;
    ok     = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = if0.in_ready;
      @(posedge clk);
      #1;
    end
    en_in = 1'b0;
    if (!ok) begin
      chk("accept_timeout", int'(ok), 1);
    end else begin
      if (beat_n == 0) grp_bias = bv;
      grp_sum += dot(d, w);
      beat_n++;
      if (beat_n == 4) begin
        for (int i = 0; i < 3; i++) sbq[i].push_back(model(grp_sum, grp_bias, relu_of[i], ow_of[i]));
        beat_n  = 0;
        grp_sum = 0;
      end
    end
  endtask

  task automatic group(input int dv, input int wv, input int bv, input int later_bv);
    send_beat(fillv(dv), fillv(wv), bv);
    for (int b = 1; b < 4; b++) send_beat(fillv(dv), fillv(wv), later_bv);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; en_in = 1'b0; out_ready = 1'b1;
    data_v = '0; w_v = '0; bias_v = '0;
    beat_n = 0; grp_sum = 0; grp_bias = 0;
    for (int i = 0; i < 3; i++) n_res[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_out", int'(if0.d_out), 0);
    chk("rst_en_out", int'(if0.en_out), 0);
    chk("rst_sat", int'(if0.sat_flag), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", int'(if0.in_ready), 1);

    // all ones: 36 / -36 clipped to 31 at OUT_W=6; en_out exactly 4 cycles after last beat
    group(1, 1, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("latency_not_early", int'(if0.en_out), 0);
    @(posedge clk); #1;
    chk("latency_t_plus_4", int'(if0.en_out), 1);
    drain();

    group(1, -1, 0, 0);
    drain();
    group(0, 0, 5, 9);
    drain();
    group(0, 0, -3, 7);
    drain();

    for (int b = 0; b < 4; b++)
      send_beat({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                int'($urandom_range(15)) - 8);
    drain();

    // back-to-back groups with the first result held for 3 cycles
    out_ready = 1'b0;
    fork
      begin
        group(1, 1, 0, 0);
        group(1, 1, 0, 0);
      end
      begin
        tw = 0;
        while (!if0.en_out && tw < 60) begin @(posedge clk); #1; tw++; end
        chk("stall_result_seen", int'(if0.en_out), 1);
        for (int c = 0; c < 3; c++) begin
          chk("stall_in_ready", int'(if0.in_ready), 0);
          chk("stall_d_out_hold", int'($signed(if0.d_out)), 36);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // async reset after two beats of a group
    base = n_res[0];
    send_beat(fillv(1), fillv(1), 0);
    send_beat(fillv(1), fillv(1), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_d_out", int'(if0.d_out), 0);
    chk("midrst_en_out", int'(if0.en_out), 0);
    chk("midrst_s6_d_out", int'(if2.d_out), 0);
    chk("midrst_s6_sat", int'(if2.sat_flag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    beat_n = 0; grp_sum = 0;
    group(1, 1, 0, 0);
    drain();
    chk("midrst_one_result", n_res[0] - base, 1);

    // clear after two beats, asserted together with a valid beat
    base = n_res[0];
    send_beat(fillv(1), fillv(1), 0);
    send_beat(fillv(1), fillv(1), 0);
    clear = 1'b1;
    en_in = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    en_in = 1'b0;
    beat_n = 0; grp_sum = 0;
    group(1, 1, 0, 0);
    drain();
    chk("clear_one_result", n_res[0] - base, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("no_late_output", n_res[0] + n_res[1] + n_res[2] - 3 * (base + 1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
